// File: rtl/io_trap_ctrl_pkg.sv
// rtl/io_trap_ctrl_pkg.sv - shared FSM encoding and I/O direction constants for io_trap_ctrl
package io_trap_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_IO = 2'd1,
      ST_NMI     = 2'd2,
      ST_TRAPPED = 2'd3
   } trap_state_t;

   localparam logic IO_DIR_IN  = 1'b1;
   localparam logic IO_DIR_OUT = 1'b0;

endpackage

// File: rtl/io_trap_ctrl_sync2.sv
// rtl/io_trap_ctrl_sync2.sv - two-flop synchroniser, resets to 1 to match idle-high Z80 strobes
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/io_trap_ctrl.sv
// rtl/io_trap_ctrl.sv - traps CPU I/O to a port window, pulses NMI, holds supervisor context until RETN
module io_trap_ctrl
   import io_trap_ctrl_pkg::*;
#(
   parameter logic [7:0] TRAP_LO    = 8'h00,
   parameter logic [7:0] TRAP_HI    = 8'hFF,
   parameter int         NMI_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       m1_n,
   input  logic       iorq_n,
   input  logic       rd_n,
   input  logic [7:0] addr,
   input  logic [7:0] data,
   input  logic       trap_enable,
   input  logic       new_isr,
   input  logic       last_isr_untrap,
   input  logic       io_direction,
   output logic       nmi_n,
   output logic       trap_active,
   output logic [7:0] trap_port,
   output logic       trap_dir,
   output logic [7:0] trap_data,
   output logic       trap_dir_err
);

   logic        m1_s, iorq_s, rd_s;
   logic        m1_d, iorq_d;
   logic        io_start, m1_fall;
   logic [8:0]  lo_diff, hi_diff;
   logic        in_window;
   logic        cap_dir;
   logic [3:0]  nmi_cnt;
   trap_state_t state;

   sync2 u_sync_m1   (.clk(clk), .rst(rst), .d(m1_n),   .q(m1_s));
   sync2 u_sync_iorq (.clk(clk), .rst(rst), .d(iorq_n), .q(iorq_s));
   sync2 u_sync_rd   (.clk(clk), .rst(rst), .d(rd_n),   .q(rd_s));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m1_d   <= 1'b1;
         iorq_d <= 1'b1;
      end else begin
         m1_d   <= m1_s;
         iorq_d <= iorq_s;
      end
   end

   // IORQ with M1 high is a true I/O cycle; IORQ with M1 low is an interrupt acknowledge
   assign io_start = iorq_d & ~iorq_s & m1_s;
   assign m1_fall  = m1_d & ~m1_s;

   // Window compare via 9-bit borrow so an all-inclusive window stays a plain compare
   assign lo_diff   = {1'b0, addr} - {1'b0, TRAP_LO};
   assign hi_diff   = {1'b0, TRAP_HI} - {1'b0, addr};
   assign in_window = ~lo_diff[8] & ~hi_diff[8];

   assign cap_dir = rd_s ? IO_DIR_OUT : IO_DIR_IN;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         nmi_n        <= 1'b1;
         trap_active  <= 1'b0;
         trap_port    <= 8'h00;
         trap_dir     <= 1'b0;
         trap_data    <= 8'h00;
         trap_dir_err <= 1'b0;
         nmi_cnt      <= 4'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (io_start && trap_enable && in_window) begin
                  trap_port    <= addr;
                  trap_dir     <= cap_dir;
                  trap_data    <= (cap_dir == IO_DIR_IN) ? 8'h00 : data;
                  trap_dir_err <= (io_direction != cap_dir);
                  state        <= ST_WAIT_IO;
               end
            end
            ST_WAIT_IO: begin
               if (iorq_s) begin
                  nmi_cnt <= NMI_CYCLES[3:0];
                  nmi_n   <= 1'b0;
                  state   <= ST_NMI;
               end
            end
            ST_NMI: begin
               // Release on the edge that takes the counter to zero: low for exactly NMI_CYCLES
               nmi_cnt <= nmi_cnt - 4'd1;
               if (nmi_cnt == 4'd1) begin
                  nmi_n       <= 1'b1;
                  trap_active <= 1'b1;
                  state       <= ST_TRAPPED;
               end
            end
            ST_TRAPPED: begin
               if (m1_fall && last_isr_untrap && new_isr) begin
                  trap_active <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
